// File: rtl/snake_sound_pkg.sv
// snake_sound_pkg: shared encodings and default durations for the game sound controller
package snake_sound_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY_EAT = 2'd1, PLAY_OVER = 2'd2, GAP = 2'd3} state_t;
  typedef enum logic [1:0] {NONE = 2'd0, EAT = 2'd1, OVER = 2'd2} pend_t;
  localparam int EAT_LEN_DEF  = 33554432;
  localparam int OVER_LEN_DEF = 134217728;
  localparam int GAP_LEN_DEF  = 4194304;
  localparam int CNT_W_DEF    = 28;
endpackage

// File: rtl/snd_dur_counter.sv
// snd_dur_counter: loadable down counter that holds at zero instead of wrapping
module snd_dur_counter #(
  parameter int CNT_W = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end
  assign zero = (cnt == '0);
endmodule

// File: rtl/sound_event_ctrl.sv
// sound_event_ctrl: turns eat/game-over pulses into held, non-overlapping speaker requests
module sound_event_ctrl
  import snake_sound_pkg::*;
#(
  parameter int EAT_LEN  = EAT_LEN_DEF,
  parameter int OVER_LEN = OVER_LEN_DEF,
  parameter int GAP_LEN  = GAP_LEN_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic eat_evt,
  input  logic over_evt,
  input  logic mute,
  output logic i_speaker,
  output logic o_speaker,
  output logic busy
);
  localparam logic [CNT_W-1:0] EAT_LD  = CNT_W'(EAT_LEN - 1);
  localparam logic [CNT_W-1:0] OVER_LD = CNT_W'(OVER_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_LEN - 1);
  state_t state, nxt;
  pend_t pend, pend_n;
  logic zero, load;
  logic [CNT_W-1:0] load_val;
  snd_dur_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .zero(zero)
  );
  always_comb begin
    nxt = state;
    pend_n = NONE;
    case (state)
      IDLE:      nxt = over_evt ? PLAY_OVER : eat_evt ? PLAY_EAT : IDLE;
      PLAY_EAT:  nxt = over_evt ? PLAY_OVER : eat_evt ? PLAY_EAT : zero ? GAP : PLAY_EAT;
      PLAY_OVER: nxt = zero ? GAP : PLAY_OVER;
      GAP: begin
        pend_n = over_evt ? OVER : (eat_evt && pend != OVER) ? EAT : pend;
        nxt = !zero ? GAP : pend_n == OVER ? PLAY_OVER : pend_n == EAT ? PLAY_EAT : IDLE;
      end
      default:   nxt = IDLE;
    endcase
    // an eat retrigger stays in PLAY_EAT but still needs a fresh duration
    load = (nxt != state) || (state == PLAY_EAT && eat_evt && !over_evt);
    load_val = nxt == PLAY_EAT ? EAT_LD : nxt == PLAY_OVER ? OVER_LD : nxt == GAP ? GAP_LD : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend <= NONE;
      i_speaker <= 1'b0;
      o_speaker <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= nxt;
      pend <= (state == GAP && !zero) ? pend_n : NONE;
      i_speaker <= (nxt == PLAY_EAT) && !mute;
      o_speaker <= (nxt == PLAY_OVER) && !mute;
      busy <= (nxt != IDLE);
    end
  end
endmodule

// File: tb/tb_sound_event_ctrl.sv
// tb_sound_event_ctrl: scoreboard bench; per-cycle expected outputs are queued with the stimulus
module tb_sound_event_ctrl;
  logic clk = 1'b0, rst = 1'b1, eat_evt = 1'b0, over_evt = 1'b0, mute = 1'b0;
  logic i_speaker, o_speaker, busy;
  int total = 0, bad = 0, e_v;
  int q[$];
  string scen = "init";
  bit ev_e[40], ev_o[40], ev_m[40], ev_r[40];
  bit ex[3][40];
  sound_event_ctrl #(.EAT_LEN(4), .OVER_LEN(8), .GAP_LEN(2), .CNT_W(28)) dut (
    .clk(clk), .rst(rst), .eat_evt(eat_evt), .over_evt(over_evt), .mute(mute),
    .i_speaker(i_speaker), .o_speaker(o_speaker), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  // expected word is {i_speaker, o_speaker, busy}
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e_v = q.pop_front();
      chk($sformatf("%s cyc%0d", scen, e_v >> 3), int'({i_speaker, o_speaker, busy}), e_v & 7);
    end
    chk("excl", int'(i_speaker & o_speaker), 0);
  end
  task automatic clr();
    for (int c = 0; c < 40; c++) begin
      ev_e[c] = 0; ev_o[c] = 0; ev_m[c] = 0; ev_r[c] = 0;
      ex[0][c] = 0; ex[1][c] = 0; ex[2][c] = 0;
    end
  endtask
  task automatic set_exp(int k, int lo, int hi);
    for (int c = lo; c <= hi; c++) ex[k][c] = 1;
  endtask
  // cycle c is the interval after edge c; edge 0 samples the initial reset
  task automatic run(string nm);
    scen = nm;
    rst = 1; eat_evt = 0; over_evt = 0; mute = 0;
    @(posedge clk); #1;
    for (int c = 0; c < 36; c++) begin
      rst = ev_r[c + 1];
      eat_evt = ev_e[c];
      over_evt = ev_o[c];
      mute = ev_m[c];
      q.push_back(c * 8 + int'({ex[0][c], ex[1][c], ex[2][c]}));
      @(posedge clk); #1;
    end
  endtask
  initial begin
    clr(); ev_e[10] = 1;
    set_exp(0, 11, 14); set_exp(2, 11, 16);
    run("basic");
    clr(); ev_e[10] = 1; ev_o[12] = 1;
    set_exp(0, 11, 12); set_exp(1, 13, 20); set_exp(2, 11, 22);
    run("preempt");
    clr(); ev_e[10] = 1; ev_e[13] = 1;
    set_exp(0, 11, 17); set_exp(2, 11, 19);
    run("retrig");
    clr(); ev_e[10] = 1; ev_o[10] = 1;
    set_exp(1, 11, 18); set_exp(2, 11, 20);
    run("simul");
    clr(); ev_e[10] = 1; ev_e[15] = 1; ev_o[16] = 1;
    set_exp(0, 11, 14); set_exp(1, 17, 24); set_exp(2, 11, 26);
    run("gap_pend");
    clr(); ev_e[10] = 1; ev_m[11] = 1; ev_m[12] = 1;
    set_exp(0, 11, 11); set_exp(0, 14, 14); set_exp(2, 11, 16);
    run("mute");
    clr(); ev_o[10] = 1; ev_r[13] = 1; ev_e[20] = 1;
    set_exp(1, 11, 12); set_exp(2, 11, 12); set_exp(0, 21, 24); set_exp(2, 21, 26);
    run("reset_mid");
    repeat (3) @(posedge clk);
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sound_event_ctrl.md
# sound_event_ctrl

Event-to-sound controller of the snake game's audio path. It converts single-cycle game event pulses into the held level requests that the music player consumes. An eat event drives `i_speaker`, the food jingle. A game-over event drives `o_speaker`, the game-over tune. The block applies priority, retrigger, minimum-gap and mute rules so the music player never sees overlapping or chattering requests.

## Interface
- `EAT_LEN`, default 33554432 (8 notes × 2^22 clk): number of cycles `i_speaker` is held per eat sound; must be ≥ 1.
- `OVER_LEN`, default 134217728 (32 notes × 2^22 clk): number of cycles `o_speaker` is held per game-over sound; must be ≥ 1.
- `GAP_LEN`, default 4194304: number of silent cycles after every sound; must be ≥ 1.
- `CNT_W`, default 28: duration counter width; each `*_LEN` must be ≤ 2^CNT_W.
- `clk`  in  1  system clock, the same clock as the music player.
- `rst`  in  1  reset; synchronous, active-high.
- `eat_evt`  in  1  single-cycle pulse, snake ate food.
- `over_evt`  in  1  single-cycle pulse, game over.
- `mute`  in  1  level; silences the outputs without stopping sequencing.
- `i_speaker`  out  1  registered request for the eat jingle.
- `o_speaker`  out  1  registered request for the game-over tune.
- `busy`  out  1  registered; high whenever the state is not IDLE.

## Operation
- The state machine has four states: IDLE, PLAY_EAT, PLAY_OVER and GAP.
- There is one down counter `cnt` of width CNT_W.
  - On entry to a state it loads LEN−1 for that state.
  - It decrements every cycle.
  - The state ends in the cycle where `cnt`==0.
- There is a one-deep pending register `pend`, taking values {NONE, EAT, OVER}.
- Event priority, applied everywhere: `over_evt` beats `eat_evt`. If both pulse in the same cycle, the eat event is dropped.
- IDLE:
  - `over_evt` → PLAY_OVER.
  - Otherwise `eat_evt` → PLAY_EAT.
  - Otherwise stay in IDLE.
- PLAY_EAT:
  - `over_evt` preempts: go to PLAY_OVER and reload `cnt`.
  - `eat_evt` retriggers: stay in PLAY_EAT and reload `cnt` with EAT_LEN−1.
  - When `cnt`==0 with no event present → GAP.
  - An event arriving in the terminal cycle takes precedence over the move to GAP.
- PLAY_OVER: `eat_evt` and `over_evt` are ignored. When `cnt`==0 → GAP.
- GAP:
  - `over_evt` sets `pend`=OVER.
  - `eat_evt` sets `pend`=EAT only if `pend`≠OVER.
  - When `cnt`==0:
    - `pend`=OVER → PLAY_OVER.
    - `pend`=EAT → PLAY_EAT.
    - Otherwise → IDLE.
  - An event arriving in the terminal cycle counts as pending.
  - `pend` clears on leaving GAP.
- Output registers, updated each cycle from the next state:
  - `i_speaker` = (next==PLAY_EAT) & ~`mute`.
  - `o_speaker` = (next==PLAY_OVER) & ~`mute`.
  - `busy` = (next≠IDLE).
- `i_speaker` and `o_speaker` are never high in the same cycle. This is an invariant, and the bench asserts it.
- `mute` gates the outputs only. State, counter and pending logic are unaffected. When mute deasserts mid-sound, the output resumes for the remaining cycles.

## Timing
- Reset: `rst` high at an edge puts the block in IDLE with `cnt`=0, `pend`=NONE and `i_speaker`=`o_speaker`=`busy`=0 from that edge on. This applies mid-sound and mid-gap. Events in the same cycle as `rst` are dropped.
- Latency: an event sampled at edge k gives an output high from edge k+1.
- Output duration: the output stays high for exactly LEN consecutive cycles, then is low for exactly GAP_LEN cycles.
- Preemption: the switch from `i_speaker` to `o_speaker` happens within one edge, with no dead cycle and no overlap.
- Retrigger: `i_speaker` stays continuously high and ends EAT_LEN cycles after the last eat pulse.
- Back-to-back sounds: a sound pending in GAP starts on the edge after the last gap cycle.
- Mute: a change on `mute` is visible at the outputs one edge later.
- Wrap-around: the counter never underflows, because every transition at `cnt`==0 reloads or leaves the state.

## Structure
- Package `snake_sound_pkg` holds:
  - the state encoding (IDLE=0, PLAY_EAT=1, PLAY_OVER=2, GAP=3);
  - the pending encoding (NONE=0, EAT=1, OVER=2);
  - the default LEN constants and CNT_W.
- Sub-module `snd_dur_counter` is a loadable down counter with inputs `load` and `load_val` and a flag output `zero`.
- The state machine, pending logic and output registers stay in the top module.

## Test plan
All scenarios use EAT_LEN=4, OVER_LEN=8, GAP_LEN=2. The bench asserts throughout that `i_speaker` and `o_speaker` are never both high.
- Basic eat: reset, then `eat_evt` at cycle 10 → `i_speaker` is 1 in cycles 11–14 and 0 in cycles 15–16; `busy` is 1 in cycles 11–16 and 0 from cycle 17.
- Preempt: `eat_evt` at cycle 10, `over_evt` at cycle 12 → `i_speaker` is 1 in cycles 11–12; `o_speaker` is 1 in cycles 13–20; the gap is cycles 21–22.
- Retrigger and simultaneous events: `eat_evt` at cycles 10 and 13 → `i_speaker` is 1 in cycles 11–17. Separately, `eat_evt` and `over_evt` together at cycle 10 → only `o_speaker`, in cycles 11–18.
- Gap pending: `eat_evt` at 10, then `eat_evt` at 15 (gap) and `over_evt` at 16 (gap) → `o_speaker` is 1 in cycles 17–24 and no eat sound follows.
- Mute: `mute` high during cycles 11–12 of an eat started at cycle 10 → `i_speaker` is 0 in cycles 12–13, 1 in cycle 14, and the gap timing is unchanged.
- Reset mid-sound: `rst` at cycle 13 during PLAY_OVER → all outputs are 0 from cycle 13; a later `eat_evt` at cycle 20 → `i_speaker` is 1 in cycles 21–24.
